// File: rtl/pulse_wave_gen.sv
// Trapezoidal pulse sequencer: emits one signed sample per clock following the
// delay/rise/high/fall/low convention, with divider-free linear ramps (DDA).
module pulse_wave_gen #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [W-1:0]  iv,
  input  logic [W-1:0]  pv,
  input  logic [CW-1:0] td,
  input  logic [CW-1:0] tr,
  input  logic [CW-1:0] th,
  input  logic [CW-1:0] tf,
  input  logic [CW-1:0] tl,
  output logic [W-1:0]  sample,
  output logic          busy,
  output logic [2:0]    phase,
  output logic          cycle_done,
  output logic          cfg_err
);

  localparam int unsigned SetupLen = 2 * (W + 1);
  localparam int unsigned SW       = $clog2(SetupLen);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StDelay = 3'd2,
    StRise  = 3'd3,
    StHigh  = 3'd4,
    StFall  = 3'd5,
    StLow   = 3'd6
  } state_e;

  // Control state
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [W-1:0]  sample_q, sample_d;
  logic          cfg_err_q, cfg_err_d;
  logic          load;

  // Latched configuration
  logic [W-1:0]  iv_q, pv_q;
  logic [CW-1:0] td_q, tr_q, th_q, tf_q, tl_q;
  logic          periodic_q;
  logic          sgn_q;
  logic [W:0]    m_q;

  // Restoring divider
  logic [W:0]    quo_q;
  logic [CW-1:0] rem_q;
  logic [W:0]    q_r_q, q_f_q;
  logic [CW-1:0] r_r_q, r_f_q;
  logic [CW-1:0] div_den;
  logic [CW:0]   div_sh, div_sub;
  logic          div_ge;
  logic [W:0]    div_quo_nx, div_q_res;
  logic [CW-1:0] div_rem_nx, div_r_res;

  // Ramp DDA
  logic [W:0]    acc_q, acc_base, acc_sum, acc_nx;
  logic [CW:0]   err_q, err_base, err_sum, err_nx;
  logic [W:0]    dda_q;
  logic [CW-1:0] dda_r, dda_den;
  logic          ramp_rise, ramp_up;
  logic [W-1:0]  ramp_base, ramp;

  // Phase sequencing
  logic          nz_d, nz_r, nz_h, nz_f, nz_l;
  state_e        succ_fall, succ_high, succ_rise, period_start, succ_setup, succ_cur;
  logic [CW-1:0] cur_len;
  logic          last_cyc, period_end;

  logic [W:0]    delta, m_in;
  logic          cfg_ok;

  assign delta  = {pv[W-1], pv} - {iv[W-1], iv};
  assign m_in   = delta[W] ? -delta : delta;
  assign cfg_ok = |{tr, th, tf, tl};

  assign nz_d = (td_q != '0);
  assign nz_r = (tr_q != '0);
  assign nz_h = (th_q != '0);
  assign nz_f = (tf_q != '0);
  assign nz_l = (tl_q != '0);

  // StIdle as a successor marks the end of a period; empty phases are skipped
  always_comb begin
    succ_fall    = nz_l ? StLow  : StIdle;
    succ_high    = nz_f ? StFall : succ_fall;
    succ_rise    = nz_h ? StHigh : succ_high;
    period_start = nz_r ? StRise : succ_rise;
    succ_setup   = nz_d ? StDelay : period_start;
  end

  always_comb begin
    cur_len  = '0;
    succ_cur = StIdle;
    unique case (state_q)
      StDelay: begin cur_len = td_q; succ_cur = period_start; end
      StRise:  begin cur_len = tr_q; succ_cur = succ_rise;    end
      StHigh:  begin cur_len = th_q; succ_cur = succ_high;    end
      StFall:  begin cur_len = tf_q; succ_cur = succ_fall;    end
      StLow:   begin cur_len = tl_q; succ_cur = StIdle;       end
      default: ;
    endcase
  end

  assign last_cyc   = (cnt_q == cur_len);
  assign period_end = (state_q inside {StRise, StHigh, StFall, StLow}) && last_cyc &&
                      (succ_cur == StIdle);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    cfg_err_d = cfg_err_q;
    load      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          if (cfg_ok) begin
            state_d   = StSetup;
            scnt_d    = '0;
            cfg_err_d = 1'b0;
            load      = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      StSetup: begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == SW'(SetupLen - 1)) begin
          state_d = succ_setup;
          cnt_d   = CW'(1);
        end
      end
      default: begin
        if (last_cyc) begin
          cnt_d = CW'(1);
          if (succ_cur == StIdle) begin
            state_d = periodic_q ? period_start : StIdle;
          end else begin
            state_d = succ_cur;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (stop && state_q != StIdle) begin
      state_d = StIdle;
    end
  end

  // One quotient bit per cycle; first W+1 cycles divide by tr, the rest by tf
  always_comb begin
    div_den    = (scnt_q <= SW'(W)) ? tr_q : tf_q;
    div_sh     = {rem_q, quo_q[W]};
    div_sub    = div_sh - {1'b0, div_den};
    div_ge     = ~div_sub[CW];
    div_quo_nx = {quo_q[W-1:0], div_ge};
    div_rem_nx = div_ge ? div_sub[CW-1:0] : div_sh[CW-1:0];
    div_q_res  = (div_den == '0) ? '0 : div_quo_nx;
    div_r_res  = (div_den == '0) ? '0 : div_rem_nx;
  end

  // DDA step toward the sample about to be shown; the fall quotient is bypassed
  // from the divider so a fall directly after setup sees it in time.
  always_comb begin
    ramp_rise = (state_d == StRise);
    dda_q     = ramp_rise ? q_r_q : ((state_q == StSetup) ? div_q_res : q_f_q);
    dda_r     = ramp_rise ? r_r_q : ((state_q == StSetup) ? div_r_res : r_f_q);
    dda_den   = ramp_rise ? tr_q : tf_q;
    acc_base  = (cnt_d == CW'(1)) ? '0 : acc_q;
    err_base  = (cnt_d == CW'(1)) ? '0 : err_q;
    acc_sum   = acc_base + dda_q;
    err_sum   = err_base + {1'b0, dda_r};
    if (err_sum >= {1'b0, dda_den}) begin
      acc_nx = acc_sum + 1'b1;
      err_nx = err_sum - {1'b0, dda_den};
    end else begin
      acc_nx = acc_sum;
      err_nx = err_sum;
    end
    ramp_base = ramp_rise ? iv_q : pv_q;
    ramp_up   = ramp_rise ^ sgn_q;
    ramp      = ramp_up ? (ramp_base + acc_nx[W-1:0]) : (ramp_base - acc_nx[W-1:0]);
  end

  always_comb begin
    sample_d = sample_q;
    if (state_q == StIdle) begin
      if (state_d == StSetup) begin
        sample_d = iv;
      end
    end else begin
      unique case (state_d)
        StRise, StFall: sample_d = ramp;
        StHigh:         sample_d = pv_q;
        StSetup:        sample_d = sample_q;
        default:        sample_d = iv_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      scnt_q    <= '0;
      sample_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scnt_q    <= scnt_d;
      sample_q  <= sample_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Datapath registers carry no reset; they are reloaded on every accepted start
  always_ff @(posedge clk) begin
    if (load) begin
      iv_q       <= iv;
      pv_q       <= pv;
      td_q       <= td;
      tr_q       <= tr;
      th_q       <= th;
      tf_q       <= tf;
      tl_q       <= tl;
      periodic_q <= periodic;
      sgn_q      <= delta[W];
      m_q        <= m_in;
      quo_q      <= m_in;
      rem_q      <= '0;
    end else if (state_q == StSetup) begin
      if (scnt_q == SW'(W)) begin
        q_r_q <= div_q_res;
        r_r_q <= div_r_res;
        quo_q <= m_q;
        rem_q <= '0;
      end else begin
        quo_q <= div_quo_nx;
        rem_q <= div_rem_nx;
      end
      if (scnt_q == SW'(SetupLen - 1)) begin
        q_f_q <= div_q_res;
        r_f_q <= div_r_res;
      end
    end
    if (state_d == StRise || state_d == StFall) begin
      acc_q <= acc_nx;
      err_q <= err_nx;
    end
  end

  assign sample     = sample_q;
  assign busy       = (state_q != StIdle);
  assign phase      = state_q;
  assign cycle_done = period_end;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Scoreboard bench for pulse_wave_gen: a waveform-level model predicts every cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_pulse_wave_gen;
  localparam int W  = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1, start = 1'b0, stop = 1'b0, periodic = 1'b0;
  logic [W-1:0]  iv = '0, pv = '0;
  logic [CW-1:0] td = '0, tr = '0, th = '0, tf = '0, tl = '0;
  logic [W-1:0]  sample;
  logic          busy, cycle_done, cfg_err;
  logic [2:0]    phase;

  always #5 clk = ~clk;

  pulse_wave_gen #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .periodic(periodic),
    .iv(iv), .pv(pv), .td(td), .tr(tr), .th(th), .tf(tf), .tl(tl),
    .sample(sample), .busy(busy), .phase(phase), .cycle_done(cycle_done), .cfg_err(cfg_err)
  );

  typedef struct { int iv; int pv; int td; int tr; int th; int tf; int tl; bit per; } cfg_t;
  typedef struct { int smp; bit busy; int ph; bit cd; bit err; } rec_t;

  rec_t exp_q[$];
  rec_t plan[$];
  cfg_t mc;
  int   held = 0;
  bit   merr = 0;
  bit   cur_busy = 0;
  int   total = 0;
  int   bad = 0;

  function automatic rec_t mk(int s, bit b, int ph);
    rec_t r;
    r.smp = s; r.busy = b; r.ph = ph; r.cd = 0; r.err = 0;
    return r;
  endfunction

  function automatic void push_n(int n, int s, int ph);
    for (int i = 0; i < n; i++) plan.push_back(mk(s, 1, ph));
  endfunction

  // Ideal linear ramp: sample k = from + sgn * floor(|to-from| * k / n)
  function automatic void push_ramp(int from, int to, int n, int ph);
    longint m;
    int     sg;
    m  = longint'(to) - longint'(from);
    sg = (m < 0) ? -1 : 1;
    if (m < 0) m = -m;
    for (int k = 1; k <= n; k++) plan.push_back(mk(from + sg * int'((m * k) / n), 1, ph));
  endfunction

  function automatic void build_period();
    rec_t last;
    push_ramp(mc.iv, mc.pv, mc.tr, 3);
    push_n(mc.th, mc.pv, 4);
    push_ramp(mc.pv, mc.iv, mc.tf, 5);
    push_n(mc.tl, mc.iv, 6);
    last = plan.pop_back();
    last.cd = 1;
    plan.push_back(last);
  endfunction

  // Outputs expected after the coming edge, given this cycle's inputs
  function automatic rec_t step(bit r, bit s, bit p, cfg_t c);
    rec_t e;
    if (r) begin
      plan.delete();
      held = 0;
      merr = 0;
      e = mk(0, 0, 0);
    end else if (cur_busy) begin
      if (p) begin
        plan.delete();
        held = mc.iv;
        e = mk(held, 0, 0);
      end else begin
        if (plan.size() == 0 && mc.per) build_period();
        if (plan.size() > 0) e = plan.pop_front();
        else begin
          held = mc.iv;
          e = mk(held, 0, 0);
        end
      end
    end else begin
      if (s && !p) begin
        if (c.tr == 0 && c.th == 0 && c.tf == 0 && c.tl == 0) merr = 1;
        else begin
          merr = 0;
          mc = c;
          push_n(2 * (W + 1), c.iv, 1);
          push_n(c.td, c.iv, 2);
          build_period();
        end
      end
      if (plan.size() > 0) e = plan.pop_front();
      else e = mk(held, 0, 0);
    end
    e.err = merr;
    cur_busy = e.busy;
    return e;
  endfunction

  function automatic cfg_t mkc(int a, int b, int d, int r, int h, int f, int l, bit per);
    cfg_t c;
    c.iv = a; c.pv = b; c.td = d; c.tr = r; c.th = h; c.tf = f; c.tl = l; c.per = per;
    return c;
  endfunction

  function automatic cfg_t rnd_cfg(int maxc);
    cfg_t c;
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    c.iv = int'($signed(a));
    c.pv = int'($signed(b));
    if ($urandom_range(0, 1) == 1) begin
      c.iv = int'($urandom_range(0, 200)) - 100;
      c.pv = int'($urandom_range(0, 200)) - 100;
    end
    c.td  = int'($urandom_range(0, maxc));
    c.tr  = int'($urandom_range(0, maxc));
    c.th  = int'($urandom_range(0, maxc));
    c.tf  = int'($urandom_range(0, maxc));
    c.tl  = int'($urandom_range(0, maxc));
    c.per = 1'($urandom_range(0, 1));
    return c;
  endfunction

  task automatic cyc(bit r, bit s, bit p, cfg_t c);
    rec_t e;
    @(negedge clk);
    rst = r; start = s; stop = p; periodic = c.per;
    iv = W'(c.iv); pv = W'(c.pv);
    td = CW'(c.td); tr = CW'(c.tr); th = CW'(c.th); tf = CW'(c.tf); tl = CW'(c.tl);
    e = step(r, s, p, c);
    exp_q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, rnd_cfg(5));
  endtask

  // Monitor: one expected record per clock edge
  rec_t got;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      total++;
      if (int'($signed(sample)) != got.smp || busy != got.busy || int'(phase) != got.ph ||
          cycle_done != got.cd || cfg_err != got.err) begin
        bad++;
        $display("FAIL cycle t=%0t: got sample=%0d busy=%0b phase=%0d done=%0b err=%0b, want sample=%0d busy=%0b phase=%0d done=%0b err=%0b",
                 $time, $signed(sample), busy, phase, cycle_done, cfg_err,
                 got.smp, got.busy, got.ph, got.cd, got.err);
      end
    end
  end

  initial begin
    cfg_t c;
    bit   r, s, p;
    repeat (3) cyc(1, 0, 0, rnd_cfg(5));

    // Single pulse, then idle holding iv
    cyc(0, 1, 0, mkc(0, 10, 2, 4, 3, 4, 3, 0));
    idle(54);

    // Downward ramp with an empty fall
    cyc(0, 1, 0, mkc(100, -50, 0, 3, 1, 0, 1, 0));
    idle(42);

    // Periodic: three-plus periods then abort
    cyc(0, 1, 0, mkc(0, 10, 2, 4, 3, 4, 3, 1));
    idle(36 + 14 * 3 + 4);
    cyc(0, 0, 1, rnd_cfg(5));
    idle(3);

    // Rejected start, then a valid one; start while busy; stop during HIGH
    cyc(0, 1, 0, mkc(5, 7, 1, 0, 0, 0, 0, 0));
    idle(3);
    cyc(0, 1, 0, mkc(-20, 20, 0, 2, 4, 2, 1, 0));
    idle(10);
    cyc(0, 1, 0, mkc(9, 9, 0, 1, 1, 1, 1, 1));
    idle(25);
    cyc(0, 0, 1, rnd_cfg(5));
    idle(3);

    // start and stop together in idle
    cyc(0, 1, 1, mkc(1, 2, 0, 1, 1, 1, 1, 0));
    idle(3);

    // Reset during RISE
    cyc(0, 1, 0, mkc(0, 1000, 0, 5, 2, 5, 2, 0));
    idle(35);
    cyc(1, 0, 0, rnd_cfg(5));
    idle(3);

    // Full-scale ramp exercises the widest dividend
    cyc(0, 1, 0, mkc(-32768, 32767, 1, 7, 1, 3, 0, 0));
    idle(50);

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      r = ($urandom_range(0, 999) == 0);
      s = ($urandom_range(0, 24) == 0);
      p = ($urandom_range(0, 149) == 0);
      c = rnd_cfg(($urandom_range(0, 3) == 0) ? 40 : 5);
      if ($urandom_range(0, 15) == 0) begin
        c.tr = 0; c.th = 0; c.tf = 0; c.tl = 0;
      end
      cyc(r, s, p, c);
    end
    idle(3);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_wave_gen.md
# pulse_wave_gen

Clocked digital stimulus sequencer that produces a sampled trapezoidal pulse/rectangular waveform, one sample per clock. It drives the controlled voltage/current sources in mixed-signal benches from a sample stream, acting as a DAC-style feed. Timing follows the source library's pulse convention: initial value, pulse value, delay, rise, high, fall and low time, with period = rise + high + fall + low. Ramps are exact linear interpolations computed without a per-cycle divider.

## Interface

- W, 16: sample width (signed two's complement)
- CW, 16: time-count width (unsigned, in clock cycles)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; latches all config inputs
- stop  in  1  synchronous abort
- periodic  in  1  latched on start; 1 = repeat rise..low forever
- iv, pv  in  W  initial value, pulse value (signed)
- td, tr, th, tf, tl  in  CW  delay, rise, high, fall, low counts
- sample  out  W  current waveform sample (registered)
- busy  out  1  high from the cycle after accepted start until return to IDLE
- phase  out  3  0 IDLE, 1 SETUP, 2 DELAY, 3 RISE, 4 HIGH, 5 FALL, 6 LOW
- cycle_done  out  1  one-cycle pulse on the last LOW cycle of each period
- cfg_err  out  1  sticky; set when start is rejected; cleared by next accepted start or rst

## Operation

- Reset: sample=0, busy=0, phase=IDLE, cycle_done=0, cfg_err=0; any run in progress is discarded.
- IDLE: start with tr+th+tf+tl != 0 is accepted; config is latched and the block enters SETUP. Start with all four zero sets cfg_err; the block stays IDLE. Start while busy is ignored.
- SETUP: sample=iv. delta = pv − iv, computed at W+1 bits; m = |delta|. A sequential restoring divider computes q_r, r_r = m / tr, then q_f, r_f = m / tf. SETUP lasts exactly 2·(W+1) cycles. A zero divisor yields q=r=0 and still consumes its W+1 cycles.
- DELAY: td cycles at sample=iv. Skipped if td=0.
- RISE: tr cycles. Cycle k (1..tr) outputs iv + sgn(delta)·floor(m·k/tr).
  - Implementation is a DDA: acc += q; err += r; if err ≥ tr then acc += 1, err −= tr.
  - The last RISE sample equals pv exactly.
  - If tr=0, RISE is skipped and HIGH begins immediately.
- HIGH: th cycles at pv.
- FALL: tf cycles. Cycle k outputs pv − sgn(delta)·floor(m·k/tf); the last sample equals iv. Skipped if tf=0.
- LOW: tl cycles at iv. On the final cycle of the period cycle_done=1, even if tl=0; in that case it fires on the last non-empty phase cycle.
  - If periodic=1, the next cycle starts RISE again; DELAY and SETUP are not repeated.
  - Otherwise the block enters IDLE with sample held at iv.
- Zero-length phases: zero-length phases emit no samples. Phase transitions chain within one clock, so no idle cycle is inserted.
- stop: any non-IDLE state → IDLE on the next edge, with sample=iv and busy=0. No cycle_done is produced. stop asserted together with start in IDLE means stop wins, and nothing is latched.
- Arithmetic: the accumulator and error registers are W+1 bits, so no overflow is possible for m ≤ 2^W − 1. Output never exceeds the [min(iv,pv), max(iv,pv)] range.

## Timing

- Accepted start at edge N gives phase=SETUP, busy=1, sample=iv at N+1.
- The first DELAY (or RISE) sample appears at edge N+1+2(W+1).
- Samples change only on clk edges. Each phase value is visible for exactly its count in cycles.
- Period in periodic mode is exactly tr+th+tf+tl cycles, measured between cycle_done pulses.
- rst mid-operation takes priority over stop and start in the same cycle.
- Config inputs are don't-care except in the start cycle.

## Test plan

- Reset: assert rst during a RISE → next cycle sample=0, busy=0, phase=0, cfg_err=0.
- Single pulse (W=16): iv=0, pv=10, td=2, tr=4, th=3, tf=4, tl=3, periodic=0. After 34 SETUP cycles the samples are 0,0 | 2,5,7,10 | 10,10,10 | 8,5,3,0 | 0,0,0. cycle_done is on the final 0; then IDLE with sample=0.
- Negative/zero-ramp: iv=100, pv=−50, tr=3, tf=0, th=1, tl=1, td=0. Rise gives 50,0,−50; high gives −50; then an immediate step to the low sample 100.
- Periodic: the single-pulse config with periodic=1 gives cycle_done every 14 cycles for ≥3 periods. The second period begins with 2 (RISE), not DELAY.
- Config error: tr=th=tf=tl=0 with start → cfg_err=1, busy stays 0. A later valid start clears cfg_err.
- Abort/collision: stop during HIGH → IDLE, sample=iv next cycle, no cycle_done. start during busy is ignored. Simultaneous start+stop in IDLE leaves the block idle.
